systolic_matmul: RTL and testbench
==================================

# systolic_matmul

Parametrised output-stationary systolic matrix multiplier. It computes D = A×B, where A is N×K and B is K×N, with K set at run time by an `in_last` marker. Operand skew is generated internally, so the producer streams one column of A and one row of B per beat with no external staggering. It adds a valid/ready handshake, an accumulate-across-tiles mode and row-serial result readout. It replaces the fixed 4×4, counter-driven multiplier in the compute datapath.

## Interface
- `N`, 4, array dimension: N×N processing elements (PEs), N ≥ 2.
- `DW`, 32, operand element width, unsigned.
- `AW`, 32, accumulator and output element width, unsigned.
- `clk` input 1: the single clock. All logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: the input beat is valid.
- `in_ready` output 1: the block accepts a beat. A beat is accepted when `in_valid && in_ready` at a rising edge.
- `in_a_flat` input N*DW: A[r][k] for the current beat k. Element r sits at bits [(N-r)*DW-1 -: DW], so element 0 is at the MSBs.
- `in_b_flat` input N*DW: B[k][c] for the current beat k. Element c sits at bits [(N-c)*DW-1 -: DW].
- `in_last` input 1: marks the final beat (k = K-1) of the tile.
- `acc_keep` input 1: sampled on the first beat of a tile only. 1 = add this tile onto the existing accumulators; 0 = clear the accumulators first.
- `out_valid` output 1: result row is valid.
- `out_ready` input 1: consumer accepts the row.
- `out_row_flat` output N*AW: D[out_row_idx][c]. Element c sits at bits [(N-c)*AW-1 -: AW].
- `out_row_idx` output $clog2(N): index of the row currently presented.
- `busy` output 1: the FSM is not in IDLE.

## Operation
**FSM states:** IDLE, LOAD, DRAIN, OUT.
- IDLE: `in_ready`=1.
  - Accepted beat with `in_last`=0 → LOAD.
  - Accepted beat with `in_last`=1 (K=1) → DRAIN.
- LOAD: `in_ready`=1. Accepted beat with `in_last`=1 → DRAIN.
- DRAIN: `in_ready`=0. Lasts exactly 2N cycles, then → OUT.
- OUT: `in_ready`=0, `out_valid`=1. Each `out_valid && out_ready` advances `out_row_idx`. Acceptance of row N-1 → IDLE, with `out_row_idx` returning to 0.

**Datapath:**
- The input is registered once. A[r] passes through a skew line of depth r and then enters PE[r][0], moving right one PE per cycle. B[c] passes through a skew line of depth c and then enters PE[0][c], moving down one PE per cycle.
- Each PE computes acc += a*b. The full 2*DW-bit product is added and the sum is truncated modulo 2^AW.
- The pipeline advances every cycle. On any cycle with no accepted beat (bubble, or any non-LOAD/IDLE state), zeros are injected, so gaps never corrupt alignment.
- Accumulator clear: on acceptance of the first beat of a tile with `acc_keep`=0, all N² accumulators are zeroed at that edge. Products of the new tile are not yet in the array at that point. With `acc_keep`=1 they are retained.
- `out_row_flat` is a mux of accumulator row `out_row_idx`. The accumulators are frozen during OUT.
- K is unbounded. Accumulators wrap and there is no overflow flag.

**Boundary conditions:**
- `in_valid` is ignored when `in_ready`=0.
- `acc_keep` and `in_last` are ignored unless their beat is accepted.
- During OUT with `out_ready`=0, `out_row_flat` and `out_row_idx` hold stable.
- `rst` in any state forces, at that edge: state IDLE, all accumulators, skew lines and PE operand registers to 0, and the in-flight tile discarded.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_row_idx`=0, `out_row_flat`=0, `busy`=0.
- Throughput: one beat per cycle while in IDLE/LOAD.
- Latency: the last beat is accepted at edge E. `out_valid` rises at edge E+2N and row 0 is presented in that cycle.
- Minimum tile duration: K + 2N + N cycles, with `out_ready` held at 1.
- The back-to-back first beat of the next tile is accepted no earlier than the cycle after row N-1 is accepted.
- `busy` is high from the edge of first-beat acceptance through the edge of row N-1 acceptance.

## Test plan
1. **Outer product.** N=4, K=1, A column [1,2,3,4], B row [5,6,7,8], `acc_keep`=0.
   - Rows: [5,6,7,8], [10,12,14,16], [15,18,21,24], [20,24,28,32].
   - `out_valid` rises exactly 8 cycles after acceptance.
2. **Identity.** K=4, A=I, B = rows [1..4], [5..8], [9..12], [13..16].
   - D equals B.
   - Repeat with `in_valid` low on alternate cycles: D identical, `in_ready` stays 1.
3. **Accumulate mode.** Run test 2 with `acc_keep`=0, then rerun the same tile with `acc_keep`=1.
   - Second result equals 2×B, e.g. row 3 = [26,28,30,32].
4. **Output backpressure.** Hold `out_ready` low for 3 cycles while row 1 is presented.
   - `out_row_idx`=1 and `out_row_flat` stay stable.
   - Rows 2 and 3 then follow.
   - `busy` falls after row 3 is accepted.
5. **Wrap.** DW=AW=32, K=1, all A=0xFFFFFFFF, all B=2.
   - Every element = 0xFFFFFFFE.
   - A K=2 repeat of the same gives 0xFFFFFFFC.
6. **Reset mid-DRAIN.** Assert `rst` 2 cycles into DRAIN.
   - Next cycle: `busy`=0, `in_ready`=1.
   - A following test-1 tile with `acc_keep`=1 still yields exactly the test-1 values, with no stale data.

Source files
------------

// File: rtl/systolic_matmul_if.sv
// Handshake and data bundle for systolic_matmul.
//   master: producer/consumer side (drives beats, accepts result rows)
//   slave : the multiplier itself
// Beat side : in_valid/in_ready, in_a_flat (A column), in_b_flat (B row),
//             in_last (final beat of tile), acc_keep (accumulate onto previous tile)
// Result    : out_valid/out_ready, out_row_flat (one D row), out_row_idx
// Status    : busy
interface systolic_matmul_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32
);
    localparam int unsigned IW = $clog2(N);

    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] in_a_flat;
    logic [N*DW-1:0] in_b_flat;
    logic            in_last;
    logic            acc_keep;
    logic            out_valid;
    logic            out_ready;
    logic [N*AW-1:0] out_row_flat;
    logic [IW-1:0]   out_row_idx;
    logic            busy;

    modport master (
        output in_valid, in_a_flat, in_b_flat, in_last, acc_keep, out_ready,
        input  in_ready, out_valid, out_row_flat, out_row_idx, busy
    );

    modport slave (
        input  in_valid, in_a_flat, in_b_flat, in_last, acc_keep, out_ready,
        output in_ready, out_valid, out_row_flat, out_row_idx, busy
    );
endinterface

// File: rtl/systolic_matmul.sv
// Output-stationary N x N systolic matrix multiplier, D = A x B.
// Each accepted beat carries one column of A and one row of B; the tile ends on in_last.
// Skew is generated internally. After the last beat the array drains for 2N cycles, then
// the N result rows are presented one per out_valid/out_ready handshake.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - systolic_matmul_if slave modport (beat input, row output, busy)
module systolic_matmul #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32
) (
    input  logic               clk,
    input  logic               rst,
    systolic_matmul_if.slave   bus
);
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned CW = $clog2(2 * N);
    localparam int unsigned PW = 2 * DW;

    typedef enum logic [1:0] {StIdle, StLoad, StDrain, StOut} stateT;

    stateT         stateQ;
    logic          inReadyQ;
    logic          outValidQ;
    logic          busyQ;
    logic [CW-1:0] drainCntQ;
    logic [IW-1:0] rowIdxQ;

    logic acceptBeat;
    logic clearAcc;

    logic [DW-1:0] aEdge [N];
    logic [DW-1:0] bEdge [N];
    logic [DW-1:0] aPe   [N][N];
    logic [DW-1:0] bPe   [N][N];
    logic [AW-1:0] acc   [N][N];
    logic [N*AW-1:0] rowFlat;

    // inReadyQ is high exactly in IDLE/LOAD, so it doubles as the "can accept" state decode.
    assign acceptBeat = bus.in_valid && inReadyQ;
    // Any accepted beat seen in IDLE is the first beat of a tile.
    assign clearAcc   = acceptBeat && (stateQ == StIdle) && !bus.acc_keep;

    // Input register (element 0) followed by r extra stages for row/column r.
    // Unaccepted cycles inject zeros so bubbles never misalign the wavefront.
    for (genvar r = 0; r < N; r++) begin : gSkew
        logic [DW-1:0] lineA [r + 1];
        logic [DW-1:0] lineB [r + 1];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int j = 0; j <= r; j++) begin
                    lineA[j] <= '0;
                    lineB[j] <= '0;
                end
            end else begin
                lineA[0] <= acceptBeat ? bus.in_a_flat[(N-r)*DW-1 -: DW] : '0;
                lineB[0] <= acceptBeat ? bus.in_b_flat[(N-r)*DW-1 -: DW] : '0;
                for (int j = 1; j <= r; j++) begin
                    lineA[j] <= lineA[j-1];
                    lineB[j] <= lineB[j-1];
                end
            end
        end

        assign aEdge[r] = lineA[r];
        assign bEdge[r] = lineB[r];
    end

    // PE array: A moves right, B moves down, accumulators stay put.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    aPe[r][c] <= '0;
                    bPe[r][c] <= '0;
                    acc[r][c] <= '0;
                end
            end
        end else begin
            for (int r = 0; r < N; r++) begin
                aPe[r][0] <= aEdge[r];
                for (int c = 1; c < N; c++) begin
                    aPe[r][c] <= aPe[r][c-1];
                end
            end
            for (int c = 0; c < N; c++) begin
                bPe[0][c] <= bEdge[c];
                for (int r = 1; r < N; r++) begin
                    bPe[r][c] <= bPe[r-1][c];
                end
            end
            // The new tile's products are still in the skew lines when clearAcc fires,
            // so clearing here cannot drop any of them.
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    if (clearAcc) begin
                        acc[r][c] <= '0;
                    end else if (stateQ != StOut) begin
                        acc[r][c] <= acc[r][c] + AW'(PW'(aPe[r][c]) * PW'(bPe[r][c]));
                    end
                end
            end
        end
    end

    // Control FSM with registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ    <= StIdle;
            inReadyQ  <= 1'b1;
            outValidQ <= 1'b0;
            busyQ     <= 1'b0;
            drainCntQ <= '0;
            rowIdxQ   <= '0;
        end else begin
            unique case (stateQ)
                StIdle: begin
                    if (acceptBeat) begin
                        busyQ     <= 1'b1;
                        drainCntQ <= '0;
                        if (bus.in_last) begin
                            stateQ   <= StDrain;
                            inReadyQ <= 1'b0;
                        end else begin
                            stateQ <= StLoad;
                        end
                    end
                end
                StLoad: begin
                    if (acceptBeat && bus.in_last) begin
                        stateQ    <= StDrain;
                        inReadyQ  <= 1'b0;
                        drainCntQ <= '0;
                    end
                end
                StDrain: begin
                    // Last beat needs 2N edges to reach PE[N-1][N-1] and be accumulated.
                    if (drainCntQ == CW'(2 * N - 1)) begin
                        stateQ    <= StOut;
                        outValidQ <= 1'b1;
                    end else begin
                        drainCntQ <= drainCntQ + CW'(1);
                    end
                end
                StOut: begin
                    if (bus.out_ready) begin
                        if (rowIdxQ == IW'(N - 1)) begin
                            rowIdxQ   <= '0;
                            stateQ    <= StIdle;
                            outValidQ <= 1'b0;
                            inReadyQ  <= 1'b1;
                            busyQ     <= 1'b0;
                        end else begin
                            rowIdxQ <= rowIdxQ + IW'(1);
                        end
                    end
                end
                default: stateQ <= StIdle;
            endcase
        end
    end

    always_comb begin
        rowFlat = '0;
        for (int c = 0; c < N; c++) begin
            rowFlat[(N-c)*AW-1 -: AW] = acc[rowIdxQ][c];
        end
    end

    assign bus.in_ready     = inReadyQ;
    assign bus.out_valid    = outValidQ;
    assign bus.busy         = busyQ;
    assign bus.out_row_idx  = rowIdxQ;
    assign bus.out_row_flat = rowFlat;
endmodule

// File: tb/tb_systolic_matmul.sv
// Directed bench for systolic_matmul (N=4, DW=AW=32).
module tb_systolic_matmul;
    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;

    localparam logic [511:0] T1 = {
        32'd5,  32'd6,  32'd7,  32'd8,
        32'd10, 32'd12, 32'd14, 32'd16,
        32'd15, 32'd18, 32'd21, 32'd24,
        32'd20, 32'd24, 32'd28, 32'd32
    };
    localparam logic [511:0] BM = {
        32'd1,  32'd2,  32'd3,  32'd4,
        32'd5,  32'd6,  32'd7,  32'd8,
        32'd9,  32'd10, 32'd11, 32'd12,
        32'd13, 32'd14, 32'd15, 32'd16
    };
    localparam logic [511:0] B2 = {
        32'd2,  32'd4,  32'd6,  32'd8,
        32'd10, 32'd12, 32'd14, 32'd16,
        32'd18, 32'd20, 32'd22, 32'd24,
        32'd26, 32'd28, 32'd30, 32'd32
    };
    localparam logic [511:0] WRAP1 = {16{32'hFFFF_FFFE}};
    localparam logic [511:0] WRAP2 = {16{32'hFFFF_FFFC}};
    localparam logic [127:0] JUNK  = {4{32'hDEAD_BEEF}};

    logic clk = 1'b0;
    logic rst;
    int   passCnt = 0;
    int   totalCnt = 0;
    int   failCnt = 0;
    int   lat;

    always #5 clk = ~clk;

    systolic_matmul_if #(.N(N), .DW(DW), .AW(AW)) bus ();

    systolic_matmul #(.N(N), .DW(DW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chkInt(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chkRow(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; the beat is accepted at the following rising edge.
    task automatic sendBeat(input logic [127:0] a, input logic [127:0] b,
                            input logic last, input logic keep);
        chkInt("in_ready_at_beat", 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.in_a_flat = a;
        bus.in_b_flat = b;
        bus.in_last   = last;
        bus.acc_keep  = keep;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.acc_keep  = 1'b0;
        bus.in_a_flat = JUNK;
        bus.in_b_flat = JUNK;
    endtask

    // A = identity, B = BM; acc_keep on later beats is the opposite of the first (must be ignored).
    task automatic identityTile(input logic keep, input bit bubbles);
        logic [127:0] a;
        logic [127:0] b;
        for (int k = 0; k < 4; k++) begin
            a = '0;
            b = '0;
            a[(4-k)*32-1 -: 32] = 32'd1;
            for (int c = 0; c < 4; c++) b[(4-c)*32-1 -: 32] = 32'(4 * k + c + 1);
            sendBeat(a, b, k == 3, (k == 0) ? keep : ~keep);
            if (bubbles && k < 3) begin
                bus.in_last = 1'b1;
                chkInt("in_ready_bubble", 32'(bus.in_ready), 32'd1);
                @(negedge clk);
                bus.in_last = 1'b0;
            end
        end
    endtask

    // Counts falling edges from "now" until out_valid is seen, bounded.
    task automatic waitOut(output int cycles);
        cycles = 0;
        while (bus.out_valid !== 1'b1 && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic readRows(input string tag, input logic [511:0] exp);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chkInt($sformatf("%s_valid%0d", tag, i), 32'(bus.out_valid), 32'd1);
            chkInt($sformatf("%s_idx%0d", tag, i), 32'(bus.out_row_idx), 32'(i));
            chkRow($sformatf("%s_row%0d", tag, i), bus.out_row_flat, exp[(4-i)*128-1 -: 128]);
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        chkInt({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
        chkInt({tag, "_ready_end"}, 32'(bus.in_ready), 32'd1);
        chkInt({tag, "_valid_end"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a_flat = '0;
        bus.in_b_flat = '0;
        bus.in_last   = 1'b0;
        bus.acc_keep  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset values
        chkInt("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chkInt("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chkInt("rst_idx", 32'(bus.out_row_idx), 32'd0);
        chkRow("rst_row", bus.out_row_flat, 128'd0);
        chkInt("rst_busy", 32'(bus.busy), 32'd0);

        // 1: outer product, K=1; in_valid held high with junk during DRAIN must be ignored
        sendBeat({32'd1, 32'd2, 32'd3, 32'd4}, {32'd5, 32'd6, 32'd7, 32'd8}, 1'b1, 1'b0);
        chkInt("t1_busy", 32'(bus.busy), 32'd1);
        chkInt("t1_in_ready_drain", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b1;
        bus.in_last  = 1'b1;
        bus.acc_keep = 1'b1;
        waitOut(lat);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.acc_keep = 1'b0;
        chkInt("t1_latency", 32'(lat), 32'd8);
        readRows("t1", T1);

        // 2: identity, contiguous then with bubbles
        identityTile(1'b0, 1'b0);
        waitOut(lat);
        chkInt("t2_latency", 32'(lat), 32'd8);
        readRows("t2", BM);
        identityTile(1'b0, 1'b1);
        waitOut(lat);
        chkInt("t2b_latency", 32'(lat), 32'd8);
        readRows("t2b", BM);

        // 3: accumulate the same tile onto the previous result
        identityTile(1'b1, 1'b0);
        waitOut(lat);
        readRows("t3", B2);

        // 4: backpressure on row 1
        identityTile(1'b0, 1'b0);
        waitOut(lat);
        bus.out_ready = 1'b1;
        chkRow("t4_row0", bus.out_row_flat, BM[511 -: 128]);
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chkInt("t4_hold_idx", 32'(bus.out_row_idx), 32'd1);
            chkRow("t4_hold_row", bus.out_row_flat, BM[383 -: 128]);
            chkInt("t4_hold_busy", 32'(bus.busy), 32'd1);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            chkInt("t4_idx", 32'(bus.out_row_idx), 32'(i));
            chkRow("t4_row", bus.out_row_flat, BM[(4-i)*128-1 -: 128]);
            chkInt("t4_busy", 32'(bus.busy), 32'd1);
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        chkInt("t4_busy_end", 32'(bus.busy), 32'd0);

        // 5: wrap modulo 2^32
        sendBeat({4{32'hFFFF_FFFF}}, {4{32'd2}}, 1'b1, 1'b0);
        waitOut(lat);
        readRows("t5a", WRAP1);
        sendBeat({4{32'hFFFF_FFFF}}, {4{32'd2}}, 1'b0, 1'b0);
        sendBeat({4{32'hFFFF_FFFF}}, {4{32'd2}}, 1'b1, 1'b0);
        waitOut(lat);
        readRows("t5b", WRAP2);

        // 6: reset two cycles into DRAIN, then a keep=1 tile must see no stale data
        sendBeat({32'd1, 32'd2, 32'd3, 32'd4}, {32'd5, 32'd6, 32'd7, 32'd8}, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        chkInt("t6_busy_pre", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chkInt("t6_busy", 32'(bus.busy), 32'd0);
        chkInt("t6_in_ready", 32'(bus.in_ready), 32'd1);
        chkInt("t6_out_valid", 32'(bus.out_valid), 32'd0);
        sendBeat({32'd1, 32'd2, 32'd3, 32'd4}, {32'd5, 32'd6, 32'd7, 32'd8}, 1'b1, 1'b1);
        waitOut(lat);
        chkInt("t6_latency", 32'(lat), 32'd8);
        readRows("t6", T1);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
